// File: rtl/cnt8_seq_ctrl_if.sv
// cnt8_seq_ctrl_if: control/data bus between the sequencer and one cnt8-style counter
interface cnt8_seq_ctrl_if #(parameter int WIDTH = 8);
    logic             cnt_pl;
    logic [WIDTH-1:0] cnt_din;
    logic             cnt_encnt;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             cnt_cin;
    logic [WIDTH-1:0] cnt_dout;
    modport master(output cnt_pl, cnt_din, cnt_encnt, cnt_inc, cnt_dec, cnt_cin, input cnt_dout);
    modport slave(input cnt_pl, cnt_din, cnt_encnt, cnt_inc, cnt_dec, cnt_cin, output cnt_dout);
endinterface

// File: rtl/cnt8_seq_ctrl.sv
// cnt8_seq_ctrl: loads a counter, runs it to its terminal value for N passes (pause via CNT_CTRL_PAUSE_EN)
module cnt8_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              mode_up_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic [PASS_W-1:0] passes_i,
    input  logic              abort_i,
`ifdef CNT_CTRL_PAUSE_EN
    input  logic              pause_i,
`endif
    output logic              ready_o,
    output logic              busy_o,
    output logic              tick_o,
    output logic              done_o,
    output logic [PASS_W-1:0] pass_cnt_o,
    cnt8_seq_ctrl_if.master   cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t            state_q;
    logic              up_q;
    logic [WIDTH-1:0]  val_q;
    logic [PASS_W-1:0] np_q;
    logic [PASS_W-1:0] pass_q;
    logic [PASS_W-1:0] pass_d;
    logic              pause;
    logic              at_term;
    logic              run;
    logic              act;
`ifdef CNT_CTRL_PAUSE_EN
    assign pause = pause_i;
`else
    assign pause = 1'b0;
`endif
    assign at_term        = cnt.cnt_dout == {WIDTH{up_q}};
    assign run            = state_q == RUN && !abort_i && !pause;
    assign act            = state_q != IDLE && !abort_i;
    assign pass_d         = pass_q + PASS_W'(1);
    assign ready_o        = state_q == IDLE;
    assign busy_o         = state_q != IDLE;
    assign tick_o         = run && at_term;
    assign done_o         = state_q == DONE && !abort_i;
    assign pass_cnt_o     = pass_q;
    assign cnt.cnt_pl     = state_q == LOAD && !abort_i;
    assign cnt.cnt_din    = cnt.cnt_pl ? val_q : '0;
    assign cnt.cnt_encnt  = run && !at_term;
    assign cnt.cnt_inc    = act && up_q;
    assign cnt.cnt_dec    = act && !up_q;
    assign cnt.cnt_cin    = 1'b0;
    // sequencer: accept, load, run to terminal, reload or finish; abort drops straight to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
            val_q   <= '0;
            np_q    <= '0;
            pass_q  <= '0;
        end else if (abort_i && state_q != IDLE) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    up_q    <= mode_up_i;
                    val_q   <= load_val_i;
                    np_q    <= passes_i == '0 ? PASS_W'(1) : passes_i;
                    pass_q  <= '0;
                    state_q <= LOAD;
                end
                LOAD: state_q <= RUN;
                RUN: if (tick_o) begin
                    pass_q  <= pass_d;
                    state_q <= pass_d == np_q ? DONE : LOAD;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
